// File: rtl/q_result_buffer.sv
// Result buffer behind the Q formula accelerator: show-ahead FIFO on a ready/valid
// master port, plus credit tracking so that results in flight always have a slot.
module q_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_in,
  output logic                    issue_ready,
  input  logic                    res_valid_in,
  input  logic [2*DATA_WIDTH-1:0] res_data_in,
  output logic                    m_valid,
  output logic [2*DATA_WIDTH-1:0] m_data,
  input  logic                    m_ready,
  output logic [CNT_WIDTH-1:0]    occupancy,
  output logic [CNT_WIDTH-1:0]    inflight,
  output logic                    err_credit,
  output logic                    err_overflow,
  output logic                    err_spurious
);
  localparam int RW = 2 * DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] INFL_MAX = '1;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push, dec;
  logic signed [CNT_WIDTH+1:0] credit;

  always_comb begin
    full = (occupancy == DEPTH_C);
    pop  = m_valid && m_ready;
    push = res_valid_in && (!full || pop);
    dec  = res_valid_in && (inflight != '0);
  end

  assign m_valid = (occupancy != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // Credit can go negative once the issuer ignores issue_ready, hence two extra bits.
  assign credit      = $signed({2'b00, DEPTH_C}) - $signed({2'b00, occupancy})
                     - $signed({2'b00, inflight});
  assign issue_ready = !credit[CNT_WIDTH+1] && (credit != '0);

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= res_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      inflight     <= '0;
      err_credit   <= 1'b0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occupancy + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

      // The accelerator returns a result for every issue, legal or not, so always count it.
      if (issue_in && !dec && inflight != INFL_MAX) inflight <= inflight + CNT_WIDTH'(1);
      else if (dec && !issue_in)                    inflight <= inflight - CNT_WIDTH'(1);

      if (issue_in && !issue_ready)         err_credit   <= 1'b1;
      if (res_valid_in && full && !pop)     err_overflow <= 1'b1;
      if (res_valid_in && inflight == '0)   err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_q_result_buffer.sv
// Directed bench for q_result_buffer (DEPTH=4): queue-based reference model checked
// every cycle, plus literal expectations along the scripted scenario.
module tb_q_result_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int INFL_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, issue_in, res_valid_in, m_ready;
  logic [2*DW-1:0] res_data_in;
  logic issue_ready, m_valid, err_credit, err_overflow, err_spurious;
  logic [2*DW-1:0] m_data;
  logic [CW-1:0] occupancy, inflight;

  q_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .issue_in(issue_in), .issue_ready(issue_ready),
    .res_valid_in(res_valid_in), .res_data_in(res_data_in),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .inflight(inflight),
    .err_credit(err_credit), .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of stored results, plain integer in-flight count.
  logic [2*DW-1:0] q[$];
  int  m_infl = 0;
  bit  m_ec = 0, m_eo = 0, m_es = 0;
  bit  cmp_en = 0;

  always @(posedge clk) begin
    bit pop_b, full_b, ready_b, push_b;
    if (reset) begin
      q.delete(); m_infl = 0; m_ec = 0; m_eo = 0; m_es = 0;
    end else begin
      pop_b   = (q.size() > 0) && m_ready;
      full_b  = (q.size() == DEPTH);
      ready_b = (DEPTH - q.size() - m_infl) > 0;
      push_b  = res_valid_in && (!full_b || pop_b);
      if (issue_in && !ready_b) m_ec = 1;
      if (res_valid_in && !push_b) m_eo = 1;
      if (pop_b) void'(q.pop_front());
      if (push_b) q.push_back(res_data_in);
      if (res_valid_in && m_infl == 0) m_es = 1;
      m_infl = m_infl + int'(issue_in) - int'(res_valid_in && m_infl > 0);
      if (m_infl > INFL_MAX) m_infl = INFL_MAX;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_valid",     m_valid,     64'(q.size() != 0));
      chk("m_data",      m_data,      (q.size() != 0) ? q[0] : 64'h0);
      chk("occupancy",   occupancy,   64'(q.size()));
      chk("inflight",    inflight,    64'(m_infl));
      chk("issue_ready", issue_ready, 64'((DEPTH - q.size() - m_infl) > 0));
      chk("err_credit",  err_credit,  64'(m_ec));
      chk("err_overflow",err_overflow,64'(m_eo));
      chk("err_spurious",err_spurious,64'(m_es));
    end
  end

  task automatic drive(input bit iss, input bit rv, input logic [63:0] d, input bit rdy);
    issue_in = iss; res_valid_in = rv; res_data_in = d; m_ready = rdy;
    @(posedge clk); #1;
  endtask

  logic [63:0] ret [4];

  initial begin
    reset = 1'b1; issue_in = 0; res_valid_in = 0; res_data_in = '0; m_ready = 0;
    @(posedge clk); #1;
    reset = 1'b0; cmp_en = 1;
    chk("rst_occ", occupancy, 0); chk("rst_infl", inflight, 0);
    chk("rst_ready", issue_ready, 1); chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);

    // Issue four operations with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, '0, 0);
      chk("issue_infl", inflight, 64'(i));
      chk("issue_ready_step", issue_ready, 64'(i < 4));
    end
    chk("issue_err_credit", err_credit, 0);

    ret[0] = 64'h1; ret[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    ret[2] = 64'h7FFF_FFFF_0000_0000; ret[3] = 64'h5;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, ret[i], 0);
      chk("ret_infl", inflight, 64'(3 - i));
      chk("ret_occ", occupancy, 64'(i + 1));
      chk("ret_ready", issue_ready, 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", m_data, ret[i]);
      drive(0, 0, '0, 1);
    end
    chk("drain_mvalid", m_valid, 0);
    chk("drain_ready", issue_ready, 1);

    // Same-cycle issue and return keeps inflight steady.
    drive(1, 0, '0, 0); drive(1, 0, '0, 0);
    drive(1, 1, 64'h21, 0);
    chk("both_infl", inflight, 2); chk("both_occ", occupancy, 1);
    drive(0, 1, 64'h22, 0); drive(0, 1, 64'h23, 0);
    chk("spur_pre", err_spurious, 0);
    drive(0, 1, 64'h24, 0);
    chk("spur_err", err_spurious, 1); chk("spur_occ", occupancy, 4);

    // Full FIFO: write alongside a pop, then write with no pop.
    drive(0, 1, 64'h9, 1);
    chk("fullpop_occ", occupancy, 4); chk("fullpop_ovf", err_overflow, 0);
    chk("fullpop_head", m_data, 64'h22);
    drive(0, 1, 64'h9, 0);
    chk("ovf_err", err_overflow, 1); chk("ovf_occ", occupancy, 4);

    // Occupancy 3, inflight 2 (the second issue ignores credit), then reset.
    drive(0, 0, '0, 1);
    drive(1, 0, '0, 0); drive(1, 0, '0, 0);
    chk("pre_rst_occ", occupancy, 3); chk("pre_rst_infl", inflight, 2);
    chk("pre_rst_ecredit", err_credit, 1);
    reset = 1'b1;
    drive(0, 0, '0, 0);
    reset = 1'b0;
    chk("mid_rst_mvalid", m_valid, 0); chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_infl", inflight, 0); chk("mid_rst_ready", issue_ready, 1);
    chk("mid_rst_errs", {err_credit, err_overflow, err_spurious}, 0);

    // Pointer wrap: ten push/pop pairs.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, '0, 0);
      drive(0, 1, 64'(i), 0);
      chk("wrap_data", m_data, 64'(i));
      drive(0, 0, '0, 1);
    end
    chk("wrap_empty", m_valid, 0);
    chk("wrap_errs", {err_credit, err_overflow, err_spurious}, 0);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
